b2b_cluster_event_arbiter: RTL and testbench

Round-robin, event-granular scheduler that shares one board-to-board output path among TOTAL_CLUSTERS input cluster FIFOs. It holds a grant from the event header to the event footer, so events are never interleaved. It pops only while the downstream FIFO has room, and discards malformed leading words. It sits between the input spy-buffer FIFOs and the board2board switching datapath.

---
 rtl/b2b_arb_pkg.sv | 17 +
 rtl/b2b_cluster_event_arbiter_rr_select.sv | 35 +++
 rtl/b2b_cluster_event_arbiter.sv | 121 ++++++++++++
 tb/tb_b2b_cluster_event_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/b2b_arb_pkg.sv
// rtl/b2b_arb_pkg.sv - shared types and helpers for the board-to-board cluster event arbiter
package b2b_arb_pkg;

    localparam int WORD_W   = 65;
    localparam int META_BIT = WORD_W - 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        BODY   = 2'd2
    } arb_state_t;

    function automatic logic is_meta(input logic [WORD_W-1:0] word);
        return word[META_BIT];
    endfunction

endpackage

// File: rtl/b2b_cluster_event_arbiter_rr_select.sv
// rtl/b2b_cluster_event_arbiter_rr_select.sv - pointer-based round-robin picker
module rr_select #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [IDX_W:0] sum;

    // Rotate requests so bit 0 is the pointer position; walk downward so the lowest offset wins.
    always_comb begin
        dbl   = {req, req} >> ptr;
        rot   = dbl[N-1:0];
        valid = 1'b0;
        idx   = '0;
        sum   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                sum = {1'b0, ptr} + (IDX_W + 1)'(k);
                if (sum >= (IDX_W + 1)'(N)) begin
                    sum = sum - (IDX_W + 1)'(N);
                end
                valid = 1'b1;
                idx   = sum[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/b2b_cluster_event_arbiter.sv
// rtl/b2b_cluster_event_arbiter.sv - event-granular round-robin arbiter onto one b2b output path
module b2b_cluster_event_arbiter
    import b2b_arb_pkg::*;
#(
    parameter int DATA_WIDTH     = 65,
    parameter int TOTAL_CLUSTERS = 4,
    parameter int SRC_W          = $clog2(TOTAL_CLUSTERS),
    parameter int CNT_W          = 32
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               arb_enable,
    input  logic [TOTAL_CLUSTERS*DATA_WIDTH-1:0] cluster_data,
    input  logic [TOTAL_CLUSTERS-1:0]          cluster_empty,
    output logic [TOTAL_CLUSTERS-1:0]          cluster_rd_req,
    output logic [DATA_WIDTH-1:0]              out_data,
    output logic                               out_wren,
    output logic [SRC_W-1:0]                   out_src,
    input  logic                               out_almost_full,
    output logic                               busy,
    output logic [CNT_W-1:0]                   evt_count,
    output logic [CNT_W-1:0]                   err_count,
    output logic                               err_pulse
);

    arb_state_t            state, state_next;
    logic [SRC_W-1:0]      grant, grant_next;
    logic [SRC_W-1:0]      rr_ptr, rr_ptr_next;
    logic                  sel_valid;
    logic [SRC_W-1:0]      sel_idx;
    logic [DATA_WIDTH-1:0] head_word;
    logic                  head_meta;
    logic                  pop, forward, discard, footer;

    rr_select #(
        .N     (TOTAL_CLUSTERS),
        .IDX_W (SRC_W)
    ) u_rr_select (
        .req   (~cluster_empty),
        .ptr   (rr_ptr),
        .valid (sel_valid),
        .idx   (sel_idx)
    );

    assign head_word = cluster_data[grant*DATA_WIDTH +: DATA_WIDTH];
    assign head_meta = head_word[DATA_WIDTH-1];
    assign busy      = (state != IDLE);

    // Grant is held header-to-footer; only the footer releases it and advances the pointer.
    always_comb begin
        state_next     = state;
        grant_next     = grant;
        rr_ptr_next    = rr_ptr;
        forward        = 1'b0;
        discard        = 1'b0;
        footer         = 1'b0;
        pop            = (state != IDLE) && !cluster_empty[grant] && !out_almost_full;
        cluster_rd_req = '0;
        cluster_rd_req[grant] = pop;
        case (state)
            IDLE: begin
                if (arb_enable && sel_valid) begin
                    grant_next = sel_idx;
                    state_next = HEADER;
                end
            end
            HEADER: begin
                if (pop) begin
                    if (head_meta) begin
                        forward    = 1'b1;
                        state_next = BODY;
                    end else begin
                        discard = 1'b1;
                    end
                end
            end
            BODY: begin
                if (pop) begin
                    forward = 1'b1;
                    if (head_meta) begin
                        footer      = 1'b1;
                        state_next  = IDLE;
                        rr_ptr_next = (grant == SRC_W'(TOTAL_CLUSTERS - 1)) ? '0 : grant + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            grant     <= '0;
            rr_ptr    <= '0;
            out_data  <= '0;
            out_wren  <= 1'b0;
            out_src   <= '0;
            evt_count <= '0;
            err_count <= '0;
            err_pulse <= 1'b0;
        end else begin
            state     <= state_next;
            grant     <= grant_next;
            rr_ptr    <= rr_ptr_next;
            out_wren  <= forward;
            err_pulse <= discard;
            if (forward) begin
                out_data <= head_word;
                out_src  <= grant;
            end
            if (footer) begin
                evt_count <= evt_count + 1'b1;
            end
            if (discard) begin
                err_count <= err_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_b2b_cluster_event_arbiter.sv
// tb/tb_b2b_cluster_event_arbiter.sv - directed scoreboard bench for the cluster event arbiter
module tb_b2b_cluster_event_arbiter;
    import b2b_arb_pkg::*;

    localparam int DW = 65;
    localparam int NC = 4;
    localparam int SW = 2;
    localparam int CW = 32;

    logic              clock = 1'b0;
    logic              reset;
    logic              arb_enable;
    logic [NC*DW-1:0]  cluster_data;
    logic [NC-1:0]     cluster_empty;
    logic [NC-1:0]     cluster_rd_req;
    logic [DW-1:0]     out_data;
    logic              out_wren;
    logic [SW-1:0]     out_src;
    logic              out_almost_full;
    logic              busy;
    logic [CW-1:0]     evt_count;
    logic [CW-1:0]     err_count;
    logic              err_pulse;

    typedef struct {
        logic [SW-1:0] src;
        logic [DW-1:0] data;
    } beat_t;

    logic [DW-1:0] fifo [NC][$];
    beat_t         exp_q[$];
    int            beat_cyc[$];
    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    int            beats = 0;
    int            err_seen = 0;

    b2b_cluster_event_arbiter #(
        .DATA_WIDTH     (DW),
        .TOTAL_CLUSTERS (NC),
        .SRC_W          (SW),
        .CNT_W          (CW)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .arb_enable      (arb_enable),
        .cluster_data    (cluster_data),
        .cluster_empty   (cluster_empty),
        .cluster_rd_req  (cluster_rd_req),
        .out_data        (out_data),
        .out_wren        (out_wren),
        .out_src         (out_src),
        .out_almost_full (out_almost_full),
        .busy            (busy),
        .evt_count       (evt_count),
        .err_count       (err_count),
        .err_pulse       (err_pulse)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [DW-1:0] mk(input logic meta, input int c, input int k);
        return {meta, 32'(c), 32'(k)};
    endfunction

    function automatic bit all_empty();
        for (int i = 0; i < NC; i++) begin
            if (fifo[i].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic load(input int c, input logic [DW-1:0] w, input bit fwd);
        fifo[c].push_back(w);
        if (fwd) exp_q.push_back('{src: SW'(c), data: w});
    endtask

    // Show-ahead FIFO model: pop on the edge the DUT pops, refresh heads away from the edge.
    initial begin
        cluster_empty = '1;
        cluster_data  = '0;
        forever begin
            @(posedge clock);
            cyc++;
            for (int i = 0; i < NC; i++) begin
                if (cluster_rd_req[i] && fifo[i].size() != 0) void'(fifo[i].pop_front());
            end
            for (int p = 0; p < 2; p++) begin
                if (p == 0) #1;
                else begin
                    @(negedge clock);
                    #2;
                end
                for (int i = 0; i < NC; i++) begin
                    cluster_empty[i] = (fifo[i].size() == 0);
                    cluster_data[i*DW +: DW] = (fifo[i].size() == 0) ? '0 : fifo[i][0];
                end
            end
        end
    end

    always @(negedge clock) begin
        if (err_pulse) err_seen++;
        if (out_wren) begin
            beats++;
            beat_cyc.push_back(cyc);
            check("beat_expected", 96'(exp_q.size() != 0), 96'd1);
            if (exp_q.size() != 0) begin
                check("beat_data", 96'(out_data), 96'(exp_q[0].data));
                check("beat_src", 96'(out_src), 96'(exp_q[0].src));
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int n = 0;
        while (!(busy == 1'b0 && all_empty() && exp_q.size() == 0) && n < limit) begin
            tick();
            n++;
        end
        check(tag, 96'(n < limit), 96'd1);
    endtask

    task automatic wait_beats(input string tag, input int target, input int limit);
        int n = 0;
        while (beats < target && n < limit) begin
            tick();
            n++;
        end
        check(tag, 96'(n < limit), 96'd1);
    endtask

    task automatic check_reset_state();
        check("rst_out_wren", 96'(out_wren), 96'd0);
        check("rst_out_data", 96'(out_data), 96'd0);
        check("rst_out_src", 96'(out_src), 96'd0);
        check("rst_busy", 96'(busy), 96'd0);
        check("rst_evt", 96'(evt_count), 96'd0);
        check("rst_err", 96'(err_count), 96'd0);
        check("rst_err_pulse", 96'(err_pulse), 96'd0);
        check("rst_rd_req", 96'(cluster_rd_req), 96'd0);
        check("rst_rr_ptr", 96'(dut.rr_ptr), 96'd0);
    endtask

    initial begin
        int base, lc, es, n;
        reset = 1'b1;
        arb_enable = 1'b1;
        out_almost_full = 1'b0;
        repeat (3) tick();
        check_reset_state();
        reset = 1'b0;
        tick();

        // four one-event clusters, served 0..3 with one bubble between events
        base = beats;
        for (int c = 0; c < NC; c++) begin
            load(c, mk(1'b1, c, 0), 1'b1);
            load(c, mk(1'b0, c, 1), 1'b1);
            load(c, mk(1'b1, c, 2), 1'b1);
        end
        wait_idle("t2_idle", 200);
        check("t2_beats", 96'(beats - base), 96'd12);
        check("t2_evt", 96'(evt_count), 96'd4);
        check("t2_rr_wrap", 96'(dut.rr_ptr), 96'd0);
        for (int e = 1; e < NC; e++) begin
            check("t2_gap", 96'(beat_cyc[base + 3*e] - beat_cyc[base + 3*e - 1]), 96'd2);
        end

        // single event on cluster 2: first beat two cycles after FIFO becomes non-empty
        base = beats;
        lc = cyc;
        load(2, mk(1'b1, 2, 'hA), 1'b1);
        load(2, mk(1'b0, 2, 'h1), 1'b1);
        load(2, mk(1'b0, 2, 'h2), 1'b1);
        load(2, mk(1'b1, 2, 'hF), 1'b1);
        wait_idle("t1_idle", 100);
        check("t1_beats", 96'(beats - base), 96'd4);
        check("t1_latency", 96'(beat_cyc[base] - lc), 96'd2);
        check("t1_evt", 96'(evt_count), 96'd5);
        check("t1_rr", 96'(dut.rr_ptr), 96'd3);

        // leading meta-clear words are discarded as errors
        es = err_seen;
        base = beats;
        load(1, mk(1'b0, 1, 'hE1), 1'b0);
        load(1, mk(1'b0, 1, 'hE2), 1'b0);
        load(1, mk(1'b1, 1, 'h10), 1'b1);
        load(1, mk(1'b0, 1, 'h11), 1'b1);
        load(1, mk(1'b1, 1, 'h12), 1'b1);
        wait_idle("t3_idle", 100);
        check("t3_beats", 96'(beats - base), 96'd3);
        check("t3_err_count", 96'(err_count), 96'd2);
        check("t3_err_pulses", 96'(err_seen - es), 96'd2);
        check("t3_evt", 96'(evt_count), 96'd6);
        check("t3_rr", 96'(dut.rr_ptr), 96'd2);

        // almost-full stall in mid-body
        base = beats;
        load(0, mk(1'b1, 0, 'h20), 1'b1);
        for (int k = 1; k <= 4; k++) load(0, mk(1'b0, 0, 'h20 + k), 1'b1);
        load(0, mk(1'b1, 0, 'h2F), 1'b1);
        wait_beats("t4_pre", base + 2, 50);
        out_almost_full = 1'b1;
        for (int s = 0; s < 5; s++) begin
            tick();
            check("t4_rd_req", 96'(cluster_rd_req), 96'd0);
            check("t4_wren", 96'(out_wren), 96'd0);
            check("t4_busy", 96'(busy), 96'd1);
        end
        out_almost_full = 1'b0;
        wait_idle("t4_idle", 100);
        check("t4_beats", 96'(beats - base), 96'd6);
        check("t4_evt", 96'(evt_count), 96'd7);
        check("t4_rr", 96'(dut.rr_ptr), 96'd1);

        // arb_enable dropped mid-event finishes the event then parks
        base = beats;
        load(3, mk(1'b1, 3, 'h30), 1'b1);
        load(3, mk(1'b0, 3, 'h31), 1'b1);
        load(3, mk(1'b0, 3, 'h32), 1'b1);
        load(3, mk(1'b1, 3, 'h33), 1'b1);
        wait_beats("t5_pre", base + 1, 50);
        arb_enable = 1'b0;
        load(0, mk(1'b1, 0, 'h40), 1'b1);
        load(0, mk(1'b1, 0, 'h41), 1'b1);
        n = 0;
        while (busy && n < 50) begin
            tick();
            n++;
        end
        check("t5_finish", 96'(n < 50), 96'd1);
        check("t5_beats", 96'(beats - base), 96'd4);
        for (int s = 0; s < 3; s++) begin
            tick();
            check("t5_park_state", 96'(dut.state), 96'(IDLE));
            check("t5_park_rd", 96'(cluster_rd_req), 96'd0);
        end
        check("t5_evt_mid", 96'(evt_count), 96'd8);
        arb_enable = 1'b1;
        wait_idle("t5_idle", 100);
        check("t5_beats_all", 96'(beats - base), 96'd6);
        check("t5_evt", 96'(evt_count), 96'd9);
        check("t5_rr", 96'(dut.rr_ptr), 96'd1);

        // reset during BODY truncates the event; leftovers become errors
        base = beats;
        load(1, mk(1'b1, 1, 'h50), 1'b1);
        load(1, mk(1'b0, 1, 'h51), 1'b1);
        wait_beats("t6_pre", base + 2, 50);
        tick();
        check("t6_in_body", 96'(dut.state), 96'(BODY));
        reset = 1'b1;
        tick();
        check_reset_state();
        reset = 1'b0;
        es = err_seen;
        load(1, mk(1'b0, 1, 'h52), 1'b0);
        load(1, mk(1'b0, 1, 'h53), 1'b0);
        load(1, mk(1'b1, 1, 'h5F), 1'b1);
        wait_beats("t6_post", base + 3, 50);
        repeat (2) tick();
        check("t6_err_count", 96'(err_count), 96'd2);
        check("t6_err_pulses", 96'(err_seen - es), 96'd2);
        check("t6_evt", 96'(evt_count), 96'd0);
        check("t6_state", 96'(dut.state), 96'(BODY));
        check("t6_exp_drained", 96'(exp_q.size()), 96'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
